// File: rtl/prog_sequence_detector_pkg.sv
// prog_seq_pkg: shared defaults, width helpers and the pattern-border function for the sequence detector.
package prog_seq_pkg;
  localparam int MAX_W = 8;
  localparam int MAX_N = 8;
  localparam int DEF_W = 2;
  localparam int DEF_N = 3;
  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_W*DEF_N-1:0] DEF_PAT = {2'b10, 2'b01, 2'b11};
  localparam int DEF_LEN = DEF_N;
  function automatic int addr_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int len_w(int n);
    return $clog2(n + 1);
  endfunction
  localparam int DEF_AW = addr_w(DEF_N);
  localparam int DEF_LW = len_w(DEF_N);
  typedef logic [MAX_N*MAX_W-1:0] wide_pat_t;
  // Symbols sit at a MAX_W stride, zero-extended, so any W <= MAX_W and N <= MAX_N fits.
  function automatic int border(wide_pat_t p, int len);
    int res;
    logic ok;
    res = 0;
    for (int b = 1; b < MAX_N; b++) begin
      ok = b < len;
      for (int i = 0; i < MAX_N - 1; i++)
        if (ok && i < b && p[i*MAX_W +: MAX_W] != p[(len-b+i)*MAX_W +: MAX_W]) ok = 1'b0;
      if (ok) res = b;
    end
    return res;
  endfunction
endpackage

// File: rtl/prog_sequence_detector_if.sv
// prog_sequence_detector_if: symbol stream, pattern programming and match outputs of the detector.
interface prog_sequence_detector_if
  import prog_seq_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int AW = addr_w(N);
  localparam int LW = len_w(N);
  logic [W-1:0] x;
  logic x_valid;
  logic overlap;
  logic pat_we;
  logic [AW-1:0] pat_addr;
  logic [W-1:0] pat_symbol;
  logic len_we;
  logic [LW-1:0] pat_len_in;
  logic cnt_clr;
  logic z;
  logic z_q;
  logic [CNT_W-1:0] match_count;
  logic [AW-1:0] state;
  modport master (
    output x, x_valid, overlap, pat_we, pat_addr, pat_symbol, len_we, pat_len_in, cnt_clr,
    input z, z_q, match_count, state
  );
  modport slave (
    input x, x_valid, overlap, pat_we, pat_addr, pat_symbol, len_we, pat_len_in, cnt_clr,
    output z, z_q, match_count, state
  );
endinterface

// File: rtl/prog_sequence_detector_seq_next_state.sv
// seq_next_state: combinational next matched-prefix length, covering extension, mismatch fallback and overlap.
module seq_next_state
  import prog_seq_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N,
  localparam int AW = addr_w(N),
  localparam int LW = len_w(N)
) (
  input  logic [N*W-1:0] pat,
  input  logic [LW-1:0]  len,
  input  logic [AW-1:0]  state,
  input  logic [W-1:0]   x,
  input  logic           overlap,
  input  logic           hit,
  output logic [AW-1:0]  nxt
);
  wide_pat_t pat_ext;
  int brd;
  int f;
  logic ok;
  always_comb begin
    pat_ext = '0;
    for (int j = 0; j < N; j++) pat_ext[j*MAX_W +: MAX_W] = MAX_W'(pat[j*W +: W]);
  end
  assign brd = border(pat_ext, int'(len));
  // Largest k whose prefix equals the tail of (pat[0..state-1], x); the last symbol is compared against x directly.
  always_comb begin
    f = 0;
    ok = 1'b0;
    for (int k = 1; k < N; k++) begin
      ok = k < int'(len) && k <= int'(state) + 1 && pat[(k-1)*W +: W] == x;
      for (int i = 0; i < N - 1; i++)
        if (ok && i < k - 1 && pat[i*W +: W] != pat[(int'(state)+1-k+i)*W +: W]) ok = 1'b0;
      if (ok) f = k;
    end
  end
  assign nxt = hit ? (overlap ? AW'(brd) : '0) : AW'(f);
endmodule

// File: rtl/prog_sequence_detector.sv
// prog_sequence_detector: Mealy detector for a runtime-programmable symbol sequence with a saturating match counter.
module prog_sequence_detector
  import prog_seq_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [W*N-1:0] DEFAULT_PAT = DEF_PAT,
  parameter int DEFAULT_LEN = N
) (
  input logic clock,
  input logic reset,
  prog_sequence_detector_if.slave bus
);
  localparam int AW = addr_w(N);
  localparam int LW = len_w(N);
  logic [N*W-1:0] pat;
  logic [LW-1:0] len;
  logic [AW-1:0] st, nxt;
  logic [CNT_W-1:0] cnt;
  logic zq, z, cfg;
  assign cfg = bus.pat_we | bus.len_we;
  assign z = bus.x_valid & ~cfg & (int'(st) == int'(len) - 1) & (bus.x == pat[(int'(len)-1)*W +: W]);
  seq_next_state #(.W(W), .N(N)) u_next (
    .pat(pat), .len(len), .state(st), .x(bus.x), .overlap(bus.overlap), .hit(z), .nxt(nxt)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat <= DEFAULT_PAT;
      len <= LW'(DEFAULT_LEN);
      st <= '0;
      zq <= 1'b0;
      cnt <= '0;
    end else begin
      zq <= z;
      cnt <= bus.cnt_clr ? '0 : cnt + CNT_W'(z && cnt != '1);
      // Any config write restarts matching so state can never reach the new length.
      if (cfg) begin
        st <= '0;
        if (bus.pat_we && int'(bus.pat_addr) < N) pat[int'(bus.pat_addr)*W +: W] <= bus.pat_symbol;
        if (bus.len_we && bus.pat_len_in != '0 && int'(bus.pat_len_in) <= N) len <= bus.pat_len_in;
      end else if (bus.x_valid) begin
        st <= nxt;
      end
    end
  end
  assign bus.z = z;
  assign bus.z_q = zq;
  assign bus.match_count = cnt;
  assign bus.state = st;
endmodule

// File: tb/tb_prog_sequence_detector.sv
// tb_prog_sequence_detector: directed vectors with hand-computed expectations for the programmable detector.
module tb_prog_sequence_detector;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fails = 0;
  prog_sequence_detector_if #(.W(2), .N(3), .CNT_W(2)) bus ();
  prog_sequence_detector #(.W(2), .N(3), .CNT_W(2)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic [1:0] sym, input int ez, input int est);
    @(negedge clock);
    bus.x = sym;
    bus.x_valid = 1'b1;
    #1 check("z", bus.z, ez);
    @(posedge clock);
    #1 check("state", bus.state, est);
    check("z_q", bus.z_q, ez);
  endtask
  task automatic idle(input logic [1:0] sym, input int est);
    @(negedge clock);
    bus.x = sym;
    bus.x_valid = 1'b0;
    #1 check("idle_z", bus.z, 0);
    @(posedge clock);
    #1 check("idle_state", bus.state, est);
  endtask
  task automatic clr();
    @(negedge clock);
    bus.x_valid = 1'b0;
    bus.cnt_clr = 1'b1;
    @(posedge clock);
    #1 check("clr_count", bus.match_count, 0);
    bus.cnt_clr = 1'b0;
  endtask
  task automatic cfg(input logic pw, input logic [1:0] addr, input logic [1:0] sym, input logic lw, input logic [1:0] plen);
    @(negedge clock);
    bus.x_valid = 1'b0;
    bus.pat_we = pw;
    bus.pat_addr = addr;
    bus.pat_symbol = sym;
    bus.len_we = lw;
    bus.pat_len_in = plen;
    @(posedge clock);
    #1 check("cfg_state", bus.state, 0);
    bus.pat_we = 1'b0;
    bus.len_we = 1'b0;
  endtask
  initial begin
    bus.x = '0;
    bus.x_valid = 1'b0;
    bus.overlap = 1'b0;
    bus.pat_we = 1'b0;
    bus.pat_addr = '0;
    bus.pat_symbol = '0;
    bus.len_we = 1'b0;
    bus.pat_len_in = '0;
    bus.cnt_clr = 1'b0;
    #1;
    check("rst_state", bus.state, 0);
    check("rst_z_q", bus.z_q, 0);
    check("rst_count", bus.match_count, 0);
    check("rst_z", bus.z, 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    // defaults 11,01,10 non-overlapping, with a stalled cycle
    send(2'b11, 0, 1);
    idle(2'b01, 1);
    send(2'b01, 0, 2);
    send(2'b10, 1, 0);
    send(2'b00, 0, 0);
    check("t1_count", bus.match_count, 1);
    // mismatch fallback keeps the 11 prefix
    clr();
    send(2'b11, 0, 1);
    send(2'b11, 0, 1);
    send(2'b01, 0, 2);
    send(2'b10, 1, 0);
    check("t2_count", bus.match_count, 1);
    // pattern 01,01 length 2
    cfg(1'b1, 2'd0, 2'b01, 1'b0, 2'd0);
    cfg(1'b1, 2'd1, 2'b01, 1'b1, 2'd2);
    clr();
    bus.overlap = 1'b1;
    send(2'b01, 0, 1);
    send(2'b01, 1, 1);
    send(2'b01, 1, 1);
    check("ovl_count", bus.match_count, 2);
    clr();
    bus.overlap = 1'b0;
    send(2'b00, 0, 0);
    send(2'b01, 0, 1);
    send(2'b01, 1, 0);
    send(2'b01, 0, 1);
    check("novl_count", bus.match_count, 1);
    // config write wins over a would-be match
    cfg(1'b1, 2'd0, 2'b11, 1'b0, 2'd0);
    cfg(1'b1, 2'd1, 2'b01, 1'b1, 2'd3);
    clr();
    send(2'b11, 0, 1);
    send(2'b01, 0, 2);
    @(negedge clock);
    bus.x = 2'b10;
    bus.x_valid = 1'b1;
    bus.pat_we = 1'b1;
    bus.pat_addr = 2'd2;
    bus.pat_symbol = 2'b00;
    #1 check("cfg_z", bus.z, 0);
    @(posedge clock);
    #1 check("cfg_prio_state", bus.state, 0);
    check("cfg_prio_count", bus.match_count, 0);
    bus.pat_we = 1'b0;
    send(2'b11, 0, 1);
    send(2'b01, 0, 2);
    send(2'b10, 0, 0);
    send(2'b11, 0, 1);
    send(2'b01, 0, 2);
    send(2'b00, 1, 0);
    check("newpat_count", bus.match_count, 1);
    // out-of-range slot and zero length are both ignored
    send(2'b11, 0, 1);
    cfg(1'b1, 2'd3, 2'b11, 1'b1, 2'd0);
    send(2'b11, 0, 1);
    send(2'b01, 0, 2);
    send(2'b00, 1, 0);
    check("illegal_count", bus.match_count, 2);
    // counter saturation and clear priority
    cfg(1'b1, 2'd2, 2'b10, 1'b0, 2'd0);
    clr();
    for (int i = 0; i < 5; i++) begin
      send(2'b11, 0, 1);
      send(2'b01, 0, 2);
      send(2'b10, 1, 0);
      check("sat_count", bus.match_count, i < 3 ? i + 1 : 3);
    end
    send(2'b11, 0, 1);
    send(2'b01, 0, 2);
    bus.cnt_clr = 1'b1;
    send(2'b10, 1, 0);
    check("clr_prio_count", bus.match_count, 0);
    bus.cnt_clr = 1'b0;
    // asynchronous reset mid-sequence
    send(2'b11, 0, 1);
    send(2'b01, 0, 2);
    send(2'b10, 1, 0);
    send(2'b11, 0, 1);
    send(2'b01, 0, 2);
    check("pre_rst_count", bus.match_count, 1);
    @(negedge clock);
    bus.x_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("arst_state", bus.state, 0);
    check("arst_z_q", bus.z_q, 0);
    check("arst_count", bus.match_count, 0);
    @(negedge clock) reset = 1'b0;
    send(2'b10, 0, 0);
    check("post_rst_count", bus.match_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/prog_sequence_detector.md
Name: prog_sequence_detector

Overview:
- Parametrised Mealy detector for a programmable sequence of up to N symbols, each W bits wide, arriving on a valid-qualified stream.
- Generalises the fixed 3-symbol, 2-bit detector with:
  - a runtime-loadable pattern and length
  - correct partial-match fallback on a mismatch
  - a selectable overlapping or non-overlapping mode
  - a saturating match counter
- Sits between a symbol source and control logic that needs a one-cycle match strobe.

Parameters:
- W, 2, symbol width in bits
- N, 3, maximum pattern length (N >= 2)
- CNT_W, 8, match counter width
- DEFAULT_PAT, {2'b10,2'b01,2'b11}, reset pattern, W*N bits, pat[0] in LSBs (default sequence 11, 01, 10)
- DEFAULT_LEN, N, reset pattern length

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- x  in  W  input symbol
- x_valid  in  1  x is consumed this cycle
- overlap  in  1  1 = overlapping matches, 0 = restart after a match
- pat_we  in  1  write pat_symbol into pat[pat_addr]
- pat_addr  in  clog2(N)  pattern slot index
- pat_symbol  in  W  pattern symbol
- len_we  in  1  write pat_len_in into the length register
- pat_len_in  in  clog2(N+1)  new pattern length
- cnt_clr  in  1  synchronous clear of match_count
- z  out  1  Mealy match strobe (combinational)
- z_q  out  1  z registered (one cycle later)
- match_count  out  CNT_W  saturating count of matches
- state  out  clog2(N)  matched-prefix length (debug)

Behaviour:
- Reset values:
  - pat = DEFAULT_PAT, len = DEFAULT_LEN
  - state = 0, z_q = 0, match_count = 0
  - z = 0 as a combinational consequence
- state k means the last k consumed symbols equal pat[0..k-1]; k is always < len.
- Config cycle: cfg = pat_we | len_we.
  - Writes take effect at the posedge and force state to 0.
  - x is ignored that cycle, and z = 0.
  - pat_addr >= N: write ignored.
  - pat_len_in = 0 or > N: write ignored; state is still cleared.
- Match strobe: z = x_valid & ~cfg & (state == len-1) & (x == pat[len-1]). z is combinational, zero added latency.
- Next state when x_valid & ~cfg:
  - z=1 and overlap=0: next state = 0.
  - z=1 and overlap=1: next state = longest proper border of pat[0..len-1], i.e. the largest b < len with pat[0..b-1] == pat[len-b..len-1].
  - z=0: next state = largest k <= state+1 with k < len, such that pat[0..k-1] equals the last k symbols of (pat[0..state-1], x). Otherwise 0.
  - The z=0 rule covers both extension (x == pat[state] gives state+1) and fallback on mismatch (e.g. pattern 11,01,10 in state 1 with x = 11 stays in state 1).
  - Implemented combinationally: O(N^2) W-bit comparators, no iteration across cycles.
- x_valid = 0: state holds and z = 0.
- z_q <= z every cycle.
- match_count:
  - increments by 1 on z = 1; saturates at 2^CNT_W - 1 (no wrap).
  - cnt_clr has priority: cnt_clr together with z gives 0.
- Length change with state >= new len is impossible, because any config write clears state.
- reset asserted mid-sequence: all registers clear asynchronously; no match is reported for the partial sequence after reset releases.

Decomposition:
- Package prog_seq_pkg holds:
  - default pattern and length constants
  - the clog2-derived width localparams
  - a function computing the pattern border
- One sub-module, seq_next_state (purely combinational):
  - inputs: pat, len, state, x, overlap, hit
  - output: next state
  - keeps the O(N^2) comparator array separate from the registers and counter.

Test Plan:
- Defaults, overlap=0, stream 11,01,10,00 -> z high only on the 3rd symbol; z_q high one cycle later; match_count = 1; state sequence 0,1,2,0,0.
- Fallback, defaults, stream 11,11,01,10 -> state 0,1,1,2; z on the 4th symbol; match_count = 1.
- Overlap: load W=2 pattern 01,01, len=2; stream 01,01,01 -> overlap=1 gives z on the 2nd and 3rd symbols (count 2); overlap=0 gives z on the 2nd only (count 1).
- Config priority: state 2; assert pat_we with x_valid and x=10 in the same cycle -> z = 0, state = 0, new symbol stored; illegal len write 0 -> len unchanged.
- Counter: CNT_W=2; five matches -> match_count = 3 (saturated); cnt_clr together with a match -> 0.
- Async reset: assert reset between clock edges while in state 2 -> state = 0, z_q = 0 and match_count = 0 immediately; next 10 gives no z.
